// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the program-counter controller: FSM state
// encoding, default widths and the next-PC source selector codes.
package pc_ctrl_pkg;

    localparam int PC_W_DEFAULT    = 10;
    localparam int INSTR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } pc_state_t;

    // Next-PC source, listed from lowest to highest priority.
    localparam logic [2:0] SRC_SEQ  = 3'd0;
    localparam logic [2:0] SRC_BR   = 3'd1;
    localparam logic [2:0] SRC_JMP  = 3'd2;
    localparam logic [2:0] SRC_CALL = 3'd3;
    localparam logic [2:0] SRC_RET  = 3'd4;

endpackage

// File: rtl/pc_incr.sv
// PC adder/subtractor: next_pc = curr_pc +/- diff, wrapping modulo 2^PC_W.
// diff is an unsigned magnitude, so a full -2^(PC_W-1) displacement fits.
module pc_incr #(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] curr_pc,
    input  logic            decr,
    input  logic [PC_W-1:0] diff,
    output logic [PC_W-1:0] next_pc
);

    // Add or subtract the magnitude; carry/borrow out is dropped to wrap.
    always_comb begin
        if (decr) begin
            next_pc = curr_pc - diff;
        end else begin
            next_pc = curr_pc + diff;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: owns the PC, runs the IDLE/FETCH/EXEC fetch
// handshake with instruction memory and resolves sequential, branch, jump,
// call and return flow using a small circular return-address stack.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int          PC_W      = PC_W_DEFAULT,
    parameter int          INSTR_W   = INSTR_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int          RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_disp,
    input  logic               jmp_valid,
    input  logic               call,
    input  logic               ret,
    input  logic [PC_W-1:0]    jmp_target,
    output logic [PC_W-1:0]    pc,
    output logic               ras_overflow,
    output logic               ras_underflow
);

    // RAS_DEPTH must be a power of two >= 2 so the pointer wraps naturally.
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pc_state_t              state_r;
    logic [PC_W-1:0]        pc_r;
    logic [INSTR_W-1:0]     instr_r;
    logic                   instr_valid_r;

    logic [PC_W-1:0]        ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]       ras_top_r;     // next free slot
    logic [CNT_W-1:0]       ras_cnt_r;
    logic                   ras_overflow_r;
    logic                   ras_underflow_r;

    logic                   resolve_s;
    logic [2:0]             src_s;
    logic                   incr_decr_s;
    logic [PC_W-1:0]        incr_diff_s;
    logic [PC_W-1:0]        incr_out_s;
    logic [PC_W-1:0]        next_pc_s;
    logic [PTR_W-1:0]       ras_top_prev_s;
    logic                   ras_full_s;
    logic                   ras_empty_s;

    assign resolve_s      = (state_r == ST_EXEC) && exec_done;
    assign ras_top_prev_s = ras_top_r - {{(PTR_W-1){1'b0}}, 1'b1};
    assign ras_full_s     = (ras_cnt_r == CNT_W'(RAS_DEPTH));
    assign ras_empty_s    = (ras_cnt_r == {CNT_W{1'b0}});

    // Resolve the next-PC source by priority: ret > call > jmp > branch > seq.
    always_comb begin
        src_s = SRC_SEQ;
        if (ret) begin
            src_s = SRC_RET;
        end else if (call) begin
            src_s = SRC_CALL;
        end else if (jmp_valid) begin
            src_s = SRC_JMP;
        end else if (br_taken) begin
            src_s = SRC_BR;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // Drive the adder: branch uses sign/magnitude of the displacement,
    // everything else (incl. call push value and empty-pop fallback) is pc+1.
    always_comb begin
        incr_decr_s = 1'b0;
        incr_diff_s = {{(PC_W-1){1'b0}}, 1'b1};
        if (src_s == SRC_BR) begin
            if (br_disp[PC_W-1]) begin
                incr_decr_s = 1'b1;
                incr_diff_s = {PC_W{1'b0}} - br_disp;
            end else begin
                incr_decr_s = 1'b0;
                incr_diff_s = br_disp;
            end
        end else begin
            incr_decr_s = 1'b0;
            incr_diff_s = {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    pc_incr #(
        .PC_W (PC_W)
    ) u_pc_incr (
        .curr_pc (pc_r),
        .decr    (incr_decr_s),
        .diff    (incr_diff_s),
        .next_pc (incr_out_s)
    );

    // Select the PC to load when the execute stage resolves.
    always_comb begin
        next_pc_s = incr_out_s;
        case (src_s)
            SRC_RET: begin
                if (ras_empty_s) begin
                    next_pc_s = incr_out_s;
                end else begin
                    next_pc_s = ras_mem_r[ras_top_prev_s];
                end
            end
            SRC_CALL: next_pc_s = jmp_target;
            SRC_JMP:  next_pc_s = jmp_target;
            SRC_BR:   next_pc_s = incr_out_s;
            SRC_SEQ:  next_pc_s = incr_out_s;
            default:  next_pc_s = incr_out_s;
        endcase
    end

    // Fetch/execute sequencer: state, PC, latched instruction and valid pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= {INSTR_W{1'b0}};
            instr_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    instr_valid_r <= 1'b0;
                    state_r       <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_r       <= imem_rdata;
                        instr_valid_r <= 1'b1;
                        state_r       <= ST_EXEC;
                    end else begin
                        instr_valid_r <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    instr_valid_r <= 1'b0;
                    if (exec_done) begin
                        pc_r    <= next_pc_s;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                default: begin
                    instr_valid_r <= 1'b0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    // Return-address stack: circular push/pop with count and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= {PC_W{1'b0}};
            end
            ras_top_r       <= {PTR_W{1'b0}};
            ras_cnt_r       <= {CNT_W{1'b0}};
            ras_overflow_r  <= 1'b0;
            ras_underflow_r <= 1'b0;
        end else if (resolve_s && (src_s == SRC_CALL)) begin
            // When full the write slot is the oldest entry, so it is replaced.
            ras_mem_r[ras_top_r] <= incr_out_s;
            ras_top_r            <= ras_top_r + {{(PTR_W-1){1'b0}}, 1'b1};
            if (ras_full_s) begin
                ras_overflow_r <= 1'b1;
            end else begin
                ras_cnt_r <= ras_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (resolve_s && (src_s == SRC_RET)) begin
            if (ras_empty_s) begin
                ras_underflow_r <= 1'b1;
            end else begin
                ras_top_r <= ras_top_prev_s;
                ras_cnt_r <= ras_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ras_top_r <= ras_top_r;
        end
    end

    assign imem_req      = (state_r == ST_FETCH);
    assign imem_addr     = pc_r;
    assign pc            = pc_r;
    assign instr         = instr_r;
    assign instr_valid   = instr_valid_r;
    assign ras_overflow  = ras_overflow_r;
    assign ras_underflow = ras_underflow_r;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: table of resolution records plus hand-written
// sequences for reset timing, back-to-back fetch, delayed ack and reset
// during fetch.
module tb_pc_ctrl;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 16;
    localparam int NVEC    = 24;

    logic               clk;
    logic               reset_n;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               exec_done;
    logic               br_taken;
    logic [PC_W-1:0]    br_disp;
    logic               jmp_valid;
    logic               call;
    logic               ret;
    logic [PC_W-1:0]    jmp_target;
    logic [PC_W-1:0]    pc;
    logic               ras_overflow;
    logic               ras_underflow;

    int n_checks;
    int n_errors;

    pc_ctrl #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .RESET_PC  (10'h000),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .exec_done     (exec_done),
        .br_taken      (br_taken),
        .br_disp       (br_disp),
        .jmp_valid     (jmp_valid),
        .call          (call),
        .ret           (ret),
        .jmp_target    (jmp_target),
        .pc            (pc),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            br_taken;
        logic [PC_W-1:0] br_disp;
        logic            jmp_valid;
        logic            call;
        logic            ret;
        logic [PC_W-1:0] jmp_target;
        logic [PC_W-1:0] exp_pc;
        logic            exp_ovf;
        logic            exp_unf;
    } vec_t;

    vec_t vec [NVEC];

    function automatic vec_t mk(logic bt, logic [PC_W-1:0] bd, logic jv, logic c,
                                logic r, logic [PC_W-1:0] jt, logic [PC_W-1:0] ep,
                                logic eo, logic eu);
        vec_t v;
        v.br_taken = bt; v.br_disp = bd; v.jmp_valid = jv; v.call = c; v.ret = r;
        v.jmp_target = jt; v.exp_pc = ep; v.exp_ovf = eo; v.exp_unf = eu;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a fetch request; an expired bound counts as a failure.
    task automatic wait_req(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: imem_req never asserted, expected 1", name);
        end
    endtask

    task automatic clear_res();
        exec_done = 1'b0; br_taken = 1'b0; br_disp = 10'h000;
        jmp_valid = 1'b0; call = 1'b0; ret = 1'b0; jmp_target = 10'h000;
    endtask

    logic [PC_W-1:0] cur_pc;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 16'h0000;
        clear_res();

        //            bt    disp    jv    call  ret   target  exp_pc  ovf   unf
        vec[0]  = mk(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 10'h004, 1'b0, 1'b0);
        vec[1]  = mk(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h010, 10'h010, 1'b0, 1'b0);
        vec[2]  = mk(1'b1, 10'h3FC, 1'b0, 1'b0, 1'b0, 10'h000, 10'h00C, 1'b0, 1'b0);
        vec[3]  = mk(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h3FE, 10'h3FE, 1'b0, 1'b0);
        vec[4]  = mk(1'b1, 10'h005, 1'b0, 1'b0, 1'b0, 10'h000, 10'h003, 1'b0, 1'b0);
        vec[5]  = mk(1'b1, 10'h200, 1'b0, 1'b0, 1'b0, 10'h000, 10'h203, 1'b0, 1'b0);
        vec[6]  = mk(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h020, 10'h020, 1'b0, 1'b0);
        vec[7]  = mk(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h100, 10'h100, 1'b0, 1'b0);
        vec[8]  = mk(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000, 10'h021, 1'b0, 1'b0);
        vec[9]  = mk(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h040, 10'h040, 1'b0, 1'b0);
        vec[10] = mk(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h050, 10'h050, 1'b0, 1'b0);
        vec[11] = mk(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h060, 10'h060, 1'b0, 1'b0);
        vec[12] = mk(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h070, 10'h070, 1'b0, 1'b0);
        vec[13] = mk(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h080, 10'h080, 1'b1, 1'b0);
        vec[14] = mk(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000, 10'h071, 1'b1, 1'b0);
        vec[15] = mk(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000, 10'h061, 1'b1, 1'b0);
        vec[16] = mk(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000, 10'h051, 1'b1, 1'b0);
        vec[17] = mk(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000, 10'h041, 1'b1, 1'b0);
        vec[18] = mk(1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 10'h000, 10'h042, 1'b1, 1'b1);
        vec[19] = mk(1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h200, 10'h200, 1'b1, 1'b1);
        vec[20] = mk(1'b1, 10'h010, 1'b1, 1'b0, 1'b1, 10'h300, 10'h043, 1'b1, 1'b1);
        vec[21] = mk(1'b1, 10'h005, 1'b1, 1'b0, 1'b0, 10'h155, 10'h155, 1'b1, 1'b1);
        vec[22] = mk(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 10'h156, 1'b1, 1'b1);
        vec[23] = mk(1'b0, 10'h0F0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h157, 1'b1, 1'b1);

        // Reset state
        tick();
        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", {22'd0, pc}, 32'h000);
        check("rst_instr", {16'd0, instr}, 32'h0000);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_ovf", {31'd0, ras_overflow}, 32'd0);
        check("rst_unf", {31'd0, ras_underflow}, 32'd0);

        // Release: one IDLE cycle, then the first request
        reset_n = 1'b1;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);

        // Zero-wait memory, exec_done always high: one request every 2 cycles
        imem_ack = 1'b1;
        exec_done = 1'b1;
        for (int k = 0; k < 7; k++) begin
            check($sformatf("stream_req%0d", k), {31'd0, imem_req}, {31'd0, ~k[0]});
            if (k[0] == 1'b0) begin
                check($sformatf("stream_addr%0d", k), {22'd0, imem_addr}, k / 2);
            end
            if (k < 6) tick();
        end
        imem_ack = 1'b0;
        exec_done = 1'b0;
        cur_pc = 10'h003;

        // Table-driven resolution records
        for (int i = 0; i < NVEC; i++) begin
            wait_req($sformatf("v%0d_req", i));
            check($sformatf("v%0d_addr", i), {22'd0, imem_addr}, {22'd0, cur_pc});
            imem_ack = 1'b1;
            imem_rdata = 16'hA500 ^ 16'(i);
            tick();
            imem_ack = 1'b0;
            check($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            check($sformatf("v%0d_instr", i), {16'd0, instr}, {16'd0, 16'hA500 ^ 16'(i)});
            exec_done = 1'b1;
            br_taken = vec[i].br_taken; br_disp = vec[i].br_disp;
            jmp_valid = vec[i].jmp_valid; call = vec[i].call; ret = vec[i].ret;
            jmp_target = vec[i].jmp_target;
            tick();
            clear_res();
            check($sformatf("v%0d_pc", i), {22'd0, pc}, {22'd0, vec[i].exp_pc});
            check($sformatf("v%0d_req_after", i), {31'd0, imem_req}, 32'd1);
            check($sformatf("v%0d_ovf", i), {31'd0, ras_overflow}, {31'd0, vec[i].exp_ovf});
            check($sformatf("v%0d_unf", i), {31'd0, ras_underflow}, {31'd0, vec[i].exp_unf});
            cur_pc = vec[i].exp_pc;
        end

        // Ack delayed 3 cycles: address held, a single valid pulse
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wait_req%0d", k), {31'd0, imem_req}, 32'd1);
            check($sformatf("wait_addr%0d", k), {22'd0, imem_addr}, 32'h157);
            check($sformatf("wait_valid%0d", k), {31'd0, instr_valid}, 32'd0);
            tick();
        end
        imem_ack = 1'b1;
        imem_rdata = 16'h1234;
        tick();
        imem_ack = 1'b0;
        check("dly_valid", {31'd0, instr_valid}, 32'd1);
        check("dly_instr", {16'd0, instr}, 32'h1234);
        tick();
        check("dly_pulse_once", {31'd0, instr_valid}, 32'd0);
        check("dly_exec_hold", {31'd0, imem_req}, 32'd0);
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        check("dly_pc", {22'd0, pc}, 32'h158);

        // Reset during FETCH with a pending ack: immediate drop, flags cleared
        imem_ack = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_pc", {22'd0, pc}, 32'h000);
        check("mid_rst_ovf", {31'd0, ras_overflow}, 32'd0);
        check("mid_rst_unf", {31'd0, ras_underflow}, 32'd0);
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        imem_ack = 1'b0;
        reset_n = 1'b1;
        tick();
        check("rerun_valid", {31'd0, instr_valid}, 32'd0);
        check("rerun_req", {31'd0, imem_req}, 32'd1);
        check("rerun_addr", {22'd0, imem_addr}, 32'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
